multiplier_radix_taint_track: RTL and testbench

//   Next-generation constant-time sequential multiplier with word-level taint tracking.

---
 rtl/multiplier_radix_taint_track.sv | 147 ++++++++++++++
 tb/tb_multiplier_radix_taint_track.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/multiplier_radix_taint_track.sv
// Constant-time radix-2^RADIX_BITS sequential multiplier (unsigned or signed
// per operation) with word-level taint tracking on data and timing outputs.
//
// state | meaning
// IDLE  | waiting for start; product/product_t hold the previous result
// RUN   | RADIX_BITS multiplier bits retired per cycle, then a final cycle
//       | in which the sign is applied to the finished sum
// DONE  | one-cycle productDone pulse, returns to IDLE unconditionally
module multiplier_radix_taint_track #(
   parameter int WIDTH      = 128,
   parameter int RADIX_BITS = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               start_t,
   input  logic               signed_mode,
   input  logic               signed_mode_t,
   input  logic [WIDTH-1:0]   multiplier,
   input  logic               multiplier_t,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic               multiplicand_t,
   output logic [2*WIDTH-1:0] product,
   output logic               product_t,
   output logic               productDone,
   output logic               productDone_t,
   output logic               busy,
   output logic               busy_t
);

   localparam int N  = WIDTH / RADIX_BITS;
   localparam int CW = $clog2(N + 1);
   localparam int SW = 2*WIDTH + RADIX_BITS;
   localparam logic [CW-1:0] LAST = CW'(N);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state;
   state_t             state_next;
   logic [CW-1:0]      counter;
   logic [WIDTH-1:0]   mplier_mag;
   logic [WIDTH-1:0]   mcand_mag;
   logic               neg;
   logic               dt;
   logic               ct;
   logic [SW-1:0]      sum;

   logic [WIDTH-1:0]   a_neg;
   logic [WIDTH-1:0]   b_neg;
   logic [WIDTH-1:0]   a_abs;
   logic [WIDTH-1:0]   b_abs;
   logic [RADIX_BITS-1:0]       digit;
   logic [WIDTH+RADIX_BITS-1:0] partial;
   logic [SW-1:0]      addend;
   logic [SW-1:0]      sum_added;
   logic [SW-1:0]      sum_step;
   logic               step_en;
   logic [2*WIDTH-1:0] prod_pos;
   logic [2*WIDTH-1:0] prod_neg;
   logic [2*WIDTH-1:0] prod_sel;

   // Operand magnitudes: both negations are always formed, the sign bit only steers the mux.
   always_comb begin
      a_neg = -multiplier;
      b_neg = -multiplicand;
      a_abs = (signed_mode & multiplier[WIDTH-1])   ? a_neg : multiplier;
      b_abs = (signed_mode & multiplicand[WIDTH-1]) ? b_neg : multiplicand;
   end

   // One digit step: the add is performed even for zero digits; the final
   // sign application always computes the negation.
   always_comb begin
      digit     = mplier_mag[RADIX_BITS-1:0];
      partial   = {{RADIX_BITS{1'b0}}, mcand_mag} * {{WIDTH{1'b0}}, digit};
      addend    = {partial, {WIDTH{1'b0}}};
      sum_added = sum + addend;
      sum_step  = sum_added >> RADIX_BITS;
      step_en   = (counter != LAST);
      prod_pos  = sum[2*WIDTH-1:0];
      prod_neg  = -prod_pos;
      prod_sel  = neg ? prod_neg : prod_pos;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (counter == LAST) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // State register, datapath registers and taint outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         counter       <= '0;
         mplier_mag    <= '0;
         mcand_mag     <= '0;
         neg           <= 1'b0;
         dt            <= 1'b0;
         ct            <= 1'b0;
         sum           <= '0;
         product       <= '0;
         product_t     <= 1'b0;
         productDone   <= 1'b0;
         productDone_t <= 1'b0;
         busy_t        <= 1'b0;
      end else begin
         state         <= state_next;
         productDone   <= 1'b0;
         productDone_t <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mplier_mag <= a_abs;
                  mcand_mag  <= b_abs;
                  neg        <= signed_mode & (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
                  dt         <= multiplier_t | multiplicand_t | signed_mode_t | start_t;
                  ct         <= start_t;
                  busy_t     <= start_t;
                  sum        <= '0;
                  counter    <= '0;
               end
            end
            RUN: begin
               if (step_en) begin
                  sum        <= sum_step;
                  mplier_mag <= mplier_mag >> RADIX_BITS;
                  counter    <= counter + CW'(1);
               end else begin
                  product       <= prod_sel;
                  product_t     <= dt;
                  productDone   <= 1'b1;
                  productDone_t <= ct;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multiplier_radix_taint_track.sv
// Scoreboard bench for multiplier_radix_taint_track at WIDTH=8, RADIX_BITS=2.
module tb_multiplier_radix_taint_track;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, start_t, signed_mode, signed_mode_t;
   logic [7:0]  multiplier, multiplicand;
   logic        multiplier_t, multiplicand_t;
   logic [15:0] product;
   logic        product_t, productDone, productDone_t, busy, busy_t;

   typedef struct {
      logic [15:0] p;
      logic        pt;
      logic        dnt;
      logic        bt;
      int          c0;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   localparam int LAT = 5;

   multiplier_radix_taint_track #(.WIDTH(8), .RADIX_BITS(2)) dut (
      .clk(clk), .rst(rst),
      .start(start), .start_t(start_t),
      .signed_mode(signed_mode), .signed_mode_t(signed_mode_t),
      .multiplier(multiplier), .multiplier_t(multiplier_t),
      .multiplicand(multiplicand), .multiplicand_t(multiplicand_t),
      .product(product), .product_t(product_t),
      .productDone(productDone), .productDone_t(productDone_t),
      .busy(busy), .busy_t(busy_t)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain integer product of the (possibly signed) operands.
   function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic m);
      longint x, y, p;
      x = m ? longint'($signed(a)) : longint'(a);
      y = m ? longint'($signed(b)) : longint'(b);
      p = x * y;
      return p[15:0];
   endfunction

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("wait_idle", 32'(busy), 32'd0);
   endtask

   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic m,
                        input logic st, input logic smt, input logic at, input logic bt);
      exp_t e;
      wait_idle();
      multiplier = a; multiplicand = b; signed_mode = m;
      start_t = st; signed_mode_t = smt; multiplier_t = at; multiplicand_t = bt;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      e.p   = ref_mul(a, b, m);
      e.pt  = at | bt | smt | st;
      e.dnt = st;
      e.bt  = st;
      e.c0  = cyc;
      q.push_back(e);
   endtask

   // Monitor: pops the scoreboard on every done pulse.
   always @(negedge clk) begin
      if (!rst) begin
         if (productDone) begin
            if (q.size() == 0) begin
               check("spurious_done", 32'(productDone), 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("product", 32'(product), 32'(e.p));
               check("product_t", 32'(product_t), 32'(e.pt));
               check("productDone_t", 32'(productDone_t), 32'(e.dnt));
               check("busy_t", 32'(busy_t), 32'(e.bt));
               check("latency", 32'(cyc - e.c0), 32'(LAT));
            end
         end else if (productDone_t) begin
            check("done_t_without_done", 32'(productDone_t), 32'd0);
         end
      end
   end

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; start_t = 1'b0; signed_mode = 1'b0; signed_mode_t = 1'b0;
      multiplier = '0; multiplier_t = 1'b0; multiplicand = '0; multiplicand_t = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_product", 32'(product), 32'd0);
      check("rst_product_t", 32'(product_t), 32'd0);
      check("rst_done", 32'(productDone), 32'd0);
      check("rst_done_t", 32'(productDone_t), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_busy_t", 32'(busy_t), 32'd0);

      do_op(8'd200, 8'd150, 1'b0, 0, 0, 0, 0);
      do_op(8'hFD, 8'h05, 1'b1, 0, 0, 0, 0);
      do_op(8'h80, 8'h80, 1'b1, 0, 0, 0, 0);
      do_op(8'd17, 8'd33, 1'b0, 0, 0, 0, 1);
      do_op(8'd17, 8'd33, 1'b0, 1, 0, 0, 0);
      do_op(8'hF0, 8'd33, 1'b1, 0, 1, 0, 0);

      // Starts during RUN and DONE must be ignored, taint included.
      do_op(8'd3, 8'd7, 1'b0, 0, 0, 0, 0);
      n = 0;
      while (busy && n < 50) begin
         multiplier = 8'd9; multiplicand = 8'd9; multiplier_t = 1'b1; start_t = 1'b1;
         start = 1'b1;
         @(negedge clk);
         n++;
      end
      start = 1'b0; start_t = 1'b0; multiplier_t = 1'b0;

      // Reset on the second RUN cycle aborts without a done pulse.
      wait_idle();
      multiplier = 8'd200; multiplicand = 8'd150; signed_mode = 1'b0;
      start_t = 1'b1; multiplicand_t = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; start_t = 1'b0; multiplicand_t = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_product", 32'(product), 32'd0);
      check("abort_product_t", 32'(product_t), 32'd0);
      check("abort_busy_t", 32'(busy_t), 32'd0);
      check("abort_done", 32'(productDone), 32'd0);
      repeat (8) @(negedge clk);

      // Latency is checked per operation, so extremes exercise constant time.
      do_op(8'd0, 8'd0, 1'b0, 0, 0, 0, 0);
      do_op(8'hFF, 8'hFF, 1'b0, 0, 0, 0, 0);
      do_op(8'h80, 8'h80, 1'b1, 0, 0, 0, 0);
      do_op(8'hFF, 8'hFF, 1'b1, 1, 1, 1, 1);

      for (int i = 0; i < 40; i++) begin
         do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      end

      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(q.size()), 32'd0);
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
